// File: rtl/exchange_link_if.sv
// exchange_link_if: one 32-bit valid/ready word stream.
//   valid : producer has a word on data this cycle
//   data  : the word; must be held stable while valid is high and ready is low
//   ready : consumer takes the word at the rising edge where valid & ready
// The exchange_link drives the order stream as master and receives the
// response stream as slave.
interface exchange_link_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/exchange_link.sv
// exchange_link: exchange-side endpoint of the two-wire serial order link.
//   clock, reset      : system clock, asynchronous active-high reset
//   data_ping_in/comEn: serial order bits and frame enable from the user board
//   order (master)    : show-ahead FIFO head towards the matching engine
//   fifo_count        : entries held (0..4)
//   drop_cnt/err_cnt  : saturating counts of frames lost to a full FIFO /
//                       frames whose bit count was not 32
//   rx_busy           : synchronised enable high while the receiver is armed
//   resp (slave)      : 32-bit response words to serialise back
//   dataPingOut/comEnOut : serial response bits and frame enable
//   tx_busy           : transmitter not idle
//   tx_state_dbg      : transmitter FSM state
module exchange_link (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_ping_in,
  input  logic             comEn,
  exchange_link_if.master  order,
  output logic [2:0]       fifo_count,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       err_cnt,
  output logic             rx_busy,
  exchange_link_if.slave   resp,
  output logic             dataPingOut,
  output logic             comEnOut,
  output logic             tx_busy,
  output logic [1:0]       tx_state_dbg
);

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  // ---------------- receiver ----------------
  logic        data_m, data_s;
  logic        en_m, en_s, en_q;
  logic        armed;
  logic [31:0] rx_sh;
  logic [5:0]  rx_bits;

  // The enable chain resets to 1 so that only a real low level on comEn
  // can arm the receiver; a frame still running at reset release is then
  // ignored whole instead of looking like a short frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_m <= 1'b0;
      data_s <= 1'b0;
      en_m   <= 1'b1;
      en_s   <= 1'b1;
      en_q   <= 1'b1;
      armed  <= 1'b0;
    end else begin
      data_m <= data_ping_in;
      data_s <= data_m;
      en_m   <= comEn;
      en_s   <= en_m;
      en_q   <= en_s;
      if (!en_s) armed <= 1'b1;
    end
  end

  logic frame_end, len_ok, fifo_full, pop, push, drop, bad;
  logic [2:0]  count;
  logic [1:0]  wr_ptr, rd_ptr, rd_next;
  logic [31:0] mem [4];
  logic [31:0] head_q;

  assign frame_end = armed & en_q & ~en_s;
  assign len_ok    = (rx_bits == 6'd32);
  assign fifo_full = (count == 3'd4);
  assign pop       = order.valid & order.ready;
  assign push      = frame_end & len_ok & (~fifo_full | pop);
  assign drop      = frame_end & len_ok & fifo_full & ~pop;
  assign bad       = frame_end & ~len_ok;
  assign rd_next   = rd_ptr + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_sh   <= '0;
      rx_bits <= '0;
    end else if (en_q && !en_s) begin
      rx_bits <= '0;
    end else if (armed && en_s) begin
      rx_sh <= {rx_sh[30:0], data_s};
      if (rx_bits != 6'd33) rx_bits <= rx_bits + 6'd1;
    end
  end

  // FIFO with a registered head word so the head holds its last value
  // when the FIFO drains empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rx_sh;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (push && count == 3'd0) begin
        head_q <= rx_sh;
      end else if (pop) begin
        // With one entry left the next head is the word arriving now, if any.
        if (count == 3'd1) begin
          if (push) head_q <= rx_sh;
        end else begin
          head_q <= mem[rd_next];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (bad && err_cnt != 8'hFF)   err_cnt  <= err_cnt + 8'd1;
    end
  end

  assign order.valid = (count != 3'd0);
  assign order.data  = head_q;
  assign fifo_count  = count;
  assign rx_busy     = en_s & armed;

  // ---------------- transmitter ----------------
  tx_state_t   state;
  logic [31:0] tx_sh;
  logic [4:0]  bit_idx;
  logic        gap_cnt;

  // Accept at edge A: bits leave on edges A+1..A+32, enable drops at A+33,
  // FSM is back in IDLE after A+34 so the next accept can land on A+35.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= TX_IDLE;
      tx_sh       <= '0;
      bit_idx     <= '0;
      gap_cnt     <= 1'b0;
      comEnOut    <= 1'b0;
      dataPingOut <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          comEnOut    <= 1'b0;
          dataPingOut <= 1'b0;
          if (resp.valid) begin
            tx_sh   <= resp.data;
            bit_idx <= 5'd31;
            state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          comEnOut    <= 1'b1;
          dataPingOut <= tx_sh[31];
          tx_sh       <= {tx_sh[30:0], 1'b0};
          if (bit_idx == 5'd0) begin
            gap_cnt <= 1'b0;
            state   <= TX_GAP;
          end else begin
            bit_idx <= bit_idx - 5'd1;
          end
        end
        TX_GAP: begin
          comEnOut    <= 1'b0;
          dataPingOut <= 1'b0;
          if (gap_cnt) state <= TX_IDLE;
          else         gap_cnt <= 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  assign resp.ready   = (state == TX_IDLE);
  assign tx_busy      = (state != TX_IDLE);
  assign tx_state_dbg = state;

endmodule

// File: tb/tb_exchange_link.sv
module tb_exchange_link;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        loop_en = 1'b0;
  logic        pin_data = 1'b0;
  logic        pin_en = 1'b0;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_cnt, err_cnt;
  logic        rx_busy, dataPingOut, comEnOut, tx_busy;
  logic [1:0]  tx_state;

  exchange_link_if order_if ();
  exchange_link_if resp_if ();

  wire data_pin = loop_en ? dataPingOut : pin_data;
  wire en_pin   = loop_en ? comEnOut : pin_en;

  exchange_link dut (
    .clock        (clock),
    .reset        (reset),
    .data_ping_in (data_pin),
    .comEn        (en_pin),
    .order        (order_if),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt),
    .err_cnt      (err_cnt),
    .rx_busy      (rx_busy),
    .resp         (resp_if),
    .dataPingOut  (dataPingOut),
    .comEnOut     (comEnOut),
    .tx_busy      (tx_busy),
    .tx_state_dbg (tx_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int m_drop, m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Sends n bits MSB first, then holds comEn low for gap cycles.
  task automatic send_frame(input logic [39:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clock);
      pin_en   = 1'b1;
      pin_data = bits[i];
    end
    @(negedge clock);
    pin_en   = 1'b0;
    pin_data = 1'b0;
    repeat (gap - 1) @(negedge clock);
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
  endtask

  task automatic pop_check(input logic [31:0] exp, input string name);
    @(negedge clock);
    check({name, " valid"}, 64'(order_if.valid), 64'd1);
    check({name, " data"}, 64'(order_if.data), 64'(exp));
    order_if.ready = 1'b1;
    @(negedge clock);
    order_if.ready = 1'b0;
  endtask

  // Reference: a finished frame of n bits lands in a 4-deep queue or is
  // counted as dropped / malformed.
  task automatic model_frame(input logic [31:0] w, input int n);
    if (n == 32) begin
      if (exp_q.size() < 4) exp_q.push_back(w);
      else if (m_drop < 255) m_drop++;
    end else if (m_err < 255) begin
      m_err++;
    end
  endtask

  typedef struct {
    int          nbits;
    logic [39:0] bits;
    int          exp_count;
    int          exp_drop;
    int          exp_err;
    logic        head_chk;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs[9];

  logic s_en[80];
  logic s_d[80];
  logic s_rdy[80];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    order_if.ready = 1'b0;
    resp_if.valid  = 1'b0;
    resp_if.data   = '0;

    vecs[0] = '{31, 40'h00_7FFF_FFFF, 0, 0, 1, 1'b0, 32'h0};
    vecs[1] = '{33, 40'h01_FFFF_FFFF, 0, 0, 2, 1'b0, 32'h0};
    vecs[2] = '{40, 40'hFF_0000_0001, 0, 0, 3, 1'b0, 32'h0};
    vecs[3] = '{32, 40'h00_A5A5_A5A5, 1, 0, 3, 1'b1, 32'hA5A5A5A5};
    vecs[4] = '{32, 40'h00_0000_0000, 2, 0, 3, 1'b1, 32'hA5A5A5A5};
    vecs[5] = '{1,  40'h00_0000_0001, 2, 0, 4, 1'b1, 32'hA5A5A5A5};
    vecs[6] = '{32, 40'h00_FFFF_FFFF, 3, 0, 4, 1'b1, 32'hA5A5A5A5};
    vecs[7] = '{32, 40'h00_1234_5678, 4, 0, 4, 1'b1, 32'hA5A5A5A5};
    vecs[8] = '{32, 40'h00_CAFE_F00D, 4, 1, 4, 1'b1, 32'hA5A5A5A5};

    // ---- reset values ----
    repeat (3) @(negedge clock);
    check("rst order_valid", 64'(order_if.valid), 64'd0);
    check("rst order_data", 64'(order_if.data), 64'd0);
    check("rst fifo_count", 64'(fifo_count), 64'd0);
    check("rst drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst err_cnt", 64'(err_cnt), 64'd0);
    check("rst rx_busy", 64'(rx_busy), 64'd0);
    check("rst comEnOut", 64'(comEnOut), 64'd0);
    check("rst dataPingOut", 64'(dataPingOut), 64'd0);
    check("rst tx_busy", 64'(tx_busy), 64'd0);
    check("rst resp_ready", 64'(resp_if.ready), 64'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // ---- table: malformed, valid and overflow frames ----
    foreach (vecs[i]) begin
      send_frame(vecs[i].bits, vecs[i].nbits, 1);
      settle();
      check($sformatf("vec%0d count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d drop", i), 64'(drop_cnt), 64'(vecs[i].exp_drop));
      check($sformatf("vec%0d err", i), 64'(err_cnt), 64'(vecs[i].exp_err));
      if (vecs[i].head_chk)
        check($sformatf("vec%0d head", i), 64'(order_if.data), 64'(vecs[i].exp_head));
    end

    // ---- full FIFO, frame end coincides with a pop ----
    send_frame(40'h00_0BAD_F00D, 32, 1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    order_if.ready = 1'b1;
    @(negedge clock);
    order_if.ready = 1'b0;
    check("coinc count", 64'(fifo_count), 64'd4);
    check("coinc drop", 64'(drop_cnt), 64'd1);
    pop_check(32'h00000000, "coinc pop0");
    pop_check(32'hFFFFFFFF, "coinc pop1");
    pop_check(32'h12345678, "coinc pop2");
    pop_check(32'h0BADF00D, "coinc pop3");
    check("drain valid", 64'(order_if.valid), 64'd0);
    check("drain hold data", 64'(order_if.data), 64'h0BADF00D);

    // ---- error counter saturation ----
    for (int i = 0; i < 260; i++) send_frame(40'h1, 1, 1);
    settle();
    check("err saturate", 64'(err_cnt), 64'd255);

    // ---- five back-to-back frames, minimum gap ----
    apply_reset();
    for (int i = 1; i <= 5; i++) send_frame(40'(i), 32, 1);
    settle();
    check("b2b count", 64'(fifo_count), 64'd4);
    check("b2b drop", 64'(drop_cnt), 64'd1);
    for (int i = 1; i <= 4; i++) pop_check(32'(i), $sformatf("b2b pop%0d", i));

    // ---- reset pulsed mid-frame with comEn held high ----
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      pin_en = 1'b1;
      pin_data = i[0];
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clock);
      pin_data = ~i[0];
    end
    @(negedge clock);
    pin_en = 1'b0;
    settle();
    check("midrst count", 64'(fifo_count), 64'd0);
    check("midrst err", 64'(err_cnt), 64'd0);
    send_frame(40'h00_1357_9BDF, 32, 1);
    settle();
    pop_check(32'h13579BDF, "midrst next");

    // ---- loopback ----
    apply_reset();
    loop_en = 1'b1;
    @(negedge clock);
    resp_if.valid = 1'b1;
    resp_if.data  = 32'hDEADBEEF;
    @(posedge clock);
    check("lb accept ready", 64'(resp_if.ready), 64'd1);
    @(negedge clock);
    resp_if.valid = 1'b0;
    repeat (35) @(negedge clock);
    check("lb early valid", 64'(order_if.valid), 64'd0);
    repeat (2) @(negedge clock);
    check("lb valid", 64'(order_if.valid), 64'd1);
    check("lb data", 64'(order_if.data), 64'hDEADBEEF);
    check("lb count", 64'(fifo_count), 64'd1);
    order_if.ready = 1'b1;
    @(negedge clock);
    order_if.ready = 1'b0;
    check("lb pop count", 64'(fifo_count), 64'd0);
    loop_en = 1'b0;

    // ---- held resp_valid, two frames ----
    apply_reset();
    resp_if.valid = 1'b1;
    resp_if.data  = 32'h80000001;
    @(posedge clock);
    @(negedge clock);
    resp_if.data = 32'h00000003;
    for (int k = 1; k < 70; k++) begin
      @(negedge clock);
      s_en[k]  = comEnOut;
      s_d[k]   = dataPingOut;
      s_rdy[k] = resp_if.ready;
    end
    resp_if.valid = 1'b0;
    begin
      int len1, rise2, len2;
      logic [31:0] w1, w2;
      len1 = 0;
      while (len1 < 40 && s_en[1 + len1]) len1++;
      rise2 = 1 + len1;
      while (rise2 < 69 && !s_en[rise2]) rise2++;
      len2 = 0;
      while (rise2 + len2 < 69 && s_en[rise2 + len2]) len2++;
      w1 = '0;
      w2 = '0;
      for (int k = 0; k < 32; k++) begin
        w1 = {w1[30:0], s_d[1 + k]};
        w2 = {w2[30:0], s_d[(rise2 + k) % 70]};
      end
      check("tx first rise", 64'(s_en[1]), 64'd1);
      check("tx pulse1 len", 64'(len1), 64'd32);
      check("tx period", 64'(rise2 - 1), 64'd35);
      check("tx pulse2 len", 64'(len2), 64'd32);
      check("tx first bit", 64'(s_d[1]), 64'd1);
      check("tx word1", 64'(w1), 64'h80000001);
      check("tx word2", 64'(w2), 64'h00000003);
      check("tx last bits", 64'({s_d[66], s_d[67]}), 64'd3);
      check("tx busy ready", 64'(s_rdy[1]), 64'd0);
      check("tx ready back", 64'(s_rdy[34]), 64'd1);
    end

    // ---- reset during SEND ----
    apply_reset();
    resp_if.valid = 1'b1;
    resp_if.data  = 32'hFFFFFFFF;
    @(posedge clock);
    @(negedge clock);
    resp_if.valid = 1'b0;
    repeat (10) @(negedge clock);
    check("txrst pre comEnOut", 64'(comEnOut), 64'd1);
    reset = 1'b1;
    #1;
    check("txrst comEnOut", 64'(comEnOut), 64'd0);
    check("txrst tx_busy", 64'(tx_busy), 64'd0);
    check("txrst ready", 64'(resp_if.ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("txrst stays idle", 64'(comEnOut), 64'd0);

    // ---- randomized frames against the reference queue ----
    apply_reset();
    exp_q.delete();
    m_drop = 0;
    m_err = 0;
    for (int f = 0; f < 30; f++) begin
      logic [31:0] w;
      int n, sel, npop;
      w = $urandom;
      sel = $urandom_range(0, 5);
      n = (sel == 0) ? 31 : (sel == 1) ? 33 : 32;
      send_frame({8'h00, w}, n, $urandom_range(1, 4));
      model_frame(w, n);
      settle();
      check($sformatf("rnd%0d count", f), 64'(fifo_count), 64'(exp_q.size()));
      check($sformatf("rnd%0d drop", f), 64'(drop_cnt), 64'(m_drop));
      check($sformatf("rnd%0d err", f), 64'(err_cnt), 64'(m_err));
      npop = $urandom_range(0, exp_q.size());
      for (int p = 0; p < npop; p++) pop_check(exp_q.pop_front(), $sformatf("rnd%0d pop", f));
    end
    while (exp_q.size() > 0) pop_check(exp_q.pop_front(), "rnd drain");
    @(negedge clock);
    check("rnd empty", 64'(order_if.valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
